// File: rtl/icache_mem_arbiter.sv
// Arbitrates the I-side DRAM read port between demand refills and stream-buffer prefetches.
// Define ICACHE_MEM_ARB_PERF_EN to add demand/prefetch/drop performance counters.
`ifndef ICACHE_LINE_WIDTH
`define ICACHE_LINE_WIDTH 128
`endif

module icache_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int CL_SIZE    = `ICACHE_LINE_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  dm_req_i,
  input  logic [ADDR_WIDTH-1:0] dm_addr_i,
  output logic                  dm_gnt_o,
  output logic                  dm_rvalid_o,
  output logic [CL_SIZE-1:0]    dm_rdata_o,
  input  logic                  pf_req_i,
  input  logic [ADDR_WIDTH-1:0] pf_addr_i,
  output logic                  pf_rvalid_o,
  output logic [CL_SIZE-1:0]    pf_rdata_o,
  output logic                  pf_busy_o,
`ifdef ICACHE_MEM_ARB_PERF_EN
  output logic [31:0]           perf_dm_cnt_o,
  output logic [31:0]           perf_pf_cnt_o,
  output logic [31:0]           perf_pf_drop_cnt_o,
`endif
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [CL_SIZE-1:0]    mem_rdata_i
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ_DM  = 3'd1,
    ST_REQ_PF  = 3'd2,
    ST_WAIT_DM = 3'd3,
    ST_WAIT_PF = 3'd4
  } state_e;

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_mem_req;
  logic                  r_drop;
  logic                  r_pf_pend;
  logic [ADDR_WIDTH-1:0] r_pf_addr;

  logic w_idle;
  logic w_pf_state;
  logic w_pf_issue;
  logic w_dm_rsp;
  logic w_pf_rsp;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_pf_state = (r_state == ST_REQ_PF) || (r_state == ST_WAIT_PF);
  assign w_pf_issue = w_idle & ~dm_req_i & r_pf_pend & ~flush_i;
  assign w_dm_rsp   = (r_state == ST_WAIT_DM) & mem_rvalid_i;
  assign w_pf_rsp   = (r_state == ST_WAIT_PF) & mem_rvalid_i;

  // Grant and response steering are combinational; rst_ni masks a grant that could not be taken.
  assign dm_gnt_o    = w_idle & dm_req_i & rst_ni;
  assign dm_rvalid_o = w_dm_rsp;
  assign dm_rdata_o  = w_dm_rsp ? mem_rdata_i : {CL_SIZE{1'b0}};
  assign pf_rvalid_o = w_pf_rsp & ~r_drop;
  assign pf_rdata_o  = (w_pf_rsp & ~r_drop) ? mem_rdata_i : {CL_SIZE{1'b0}};
  assign pf_busy_o   = r_pf_pend | w_pf_state;
  assign mem_req_o   = r_mem_req;
  assign mem_addr_o  = r_addr;

  // Transaction FSM: one outstanding memory request, response routed by state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_IDLE;
      r_addr    <= {ADDR_WIDTH{1'b0}};
      r_mem_req <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (dm_req_i) begin
            r_addr    <= dm_addr_i;
            r_mem_req <= 1'b1;
            r_state   <= ST_REQ_DM;
          end else if (w_pf_issue) begin
            r_addr    <= r_pf_addr;
            r_mem_req <= 1'b1;
            r_state   <= ST_REQ_PF;
          end
        end
        ST_REQ_DM: begin
          if (mem_gnt_i) begin
            r_mem_req <= 1'b0;
            r_state   <= ST_WAIT_DM;
          end
        end
        ST_REQ_PF: begin
          // A flushed prefetch still completes its handshake; only the data is dropped.
          if (flush_i) begin
            r_drop <= 1'b1;
          end
          if (mem_gnt_i) begin
            r_mem_req <= 1'b0;
            r_state   <= ST_WAIT_PF;
          end
        end
        ST_WAIT_DM: begin
          if (mem_rvalid_i) begin
            r_state <= ST_IDLE;
          end
        end
        ST_WAIT_PF: begin
          if (mem_rvalid_i) begin
            r_drop  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (flush_i) begin
            r_drop <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_mem_req <= 1'b0;
          r_drop    <= 1'b0;
        end
      endcase
    end
  end

  // One-entry prefetch slot: newest pulse wins, flush empties it and discards a same-cycle pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pf_pend <= 1'b0;
      r_pf_addr <= {ADDR_WIDTH{1'b0}};
    end else if (flush_i) begin
      r_pf_pend <= 1'b0;
    end else if (pf_req_i) begin
      r_pf_pend <= 1'b1;
      r_pf_addr <= pf_addr_i;
    end else if (w_pf_issue) begin
      r_pf_pend <= 1'b0;
    end
  end

`ifdef ICACHE_MEM_ARB_PERF_EN
  logic w_pf_overwrite;
  logic w_pf_kill;
  logic w_pf_swallow;
  logic [31:0] r_perf_dm;
  logic [31:0] r_perf_pf;
  logic [31:0] r_perf_drop;

  assign w_pf_overwrite = pf_req_i & r_pf_pend & ~flush_i & ~w_pf_issue;
  assign w_pf_kill      = flush_i & r_pf_pend;
  assign w_pf_swallow   = w_pf_rsp & r_drop;

  assign perf_dm_cnt_o      = r_perf_dm;
  assign perf_pf_cnt_o      = r_perf_pf;
  assign perf_pf_drop_cnt_o = r_perf_drop;

  // Free-running wrapping event counters, untouched by flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf_dm   <= 32'd0;
      r_perf_pf   <= 32'd0;
      r_perf_drop <= 32'd0;
    end else begin
      r_perf_dm   <= r_perf_dm + {31'd0, dm_gnt_o};
      r_perf_pf   <= r_perf_pf + {31'd0, w_pf_issue};
      r_perf_drop <= r_perf_drop + {31'd0, w_pf_overwrite} + {31'd0, w_pf_kill}
                     + {31'd0, w_pf_swallow};
    end
  end
`endif

endmodule

// File: tb/tb_icache_mem_arbiter.sv
// Scoreboard bench for icache_mem_arbiter: directed stimulus, expected traffic queued, monitor compares.
`timescale 1ns/1ps

module tb_icache_mem_arbiter;

  localparam int AW = 32;
  localparam int CL = 128;

  localparam logic [CL-1:0] D_A5 = {16{8'hA5}};
  localparam logic [CL-1:0] D_1  = {4{32'h1111_0001}};
  localparam logic [CL-1:0] D_2  = {4{32'h2222_0002}};
  localparam logic [CL-1:0] D_3  = {4{32'h3333_0003}};
  localparam logic [CL-1:0] D_4  = {4{32'h4444_0004}};
  localparam logic [CL-1:0] D_5  = {4{32'h5555_0005}};
  localparam logic [CL-1:0] D_X  = {4{32'hDEAD_BEEF}};

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          flush_i = 1'b0;
  logic          dm_req_i = 1'b0;
  logic [AW-1:0] dm_addr_i = '0;
  logic          dm_gnt_o;
  logic          dm_rvalid_o;
  logic [CL-1:0] dm_rdata_o;
  logic          pf_req_i = 1'b0;
  logic [AW-1:0] pf_addr_i = '0;
  logic          pf_rvalid_o;
  logic [CL-1:0] pf_rdata_o;
  logic          pf_busy_o;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_gnt_i = 1'b0;
  logic          mem_rvalid_i = 1'b0;
  logic [CL-1:0] mem_rdata_i = '0;
`ifdef ICACHE_MEM_ARB_PERF_EN
  logic [31:0]   perf_dm_cnt_o;
  logic [31:0]   perf_pf_cnt_o;
  logic [31:0]   perf_pf_drop_cnt_o;
`endif

  icache_mem_arbiter #(.ADDR_WIDTH(AW), .CL_SIZE(CL)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
    .dm_req_i(dm_req_i), .dm_addr_i(dm_addr_i), .dm_gnt_o(dm_gnt_o),
    .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
    .pf_req_i(pf_req_i), .pf_addr_i(pf_addr_i), .pf_rvalid_o(pf_rvalid_o),
    .pf_rdata_o(pf_rdata_o), .pf_busy_o(pf_busy_o),
`ifdef ICACHE_MEM_ARB_PERF_EN
    .perf_dm_cnt_o(perf_dm_cnt_o), .perf_pf_cnt_o(perf_pf_cnt_o),
    .perf_pf_drop_cnt_o(perf_pf_drop_cnt_o),
`endif
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] exp_mem[$];
  logic [CL-1:0] exp_dm[$];
  logic [CL-1:0] exp_pf[$];

  task automatic check(input string name, input logic [CL-1:0] act, input logic [CL-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory-side responder: wait for a request, grant after gdly cycles, respond after rdly more.
  task automatic serve(input int gdly, input int rdly, input logic [CL-1:0] data);
    int i = 0;
    while (!mem_req_o && i < 100) begin
      tick();
      i++;
    end
    check("serve_req_seen", mem_req_o, 1);
    if (mem_req_o) begin
      repeat (gdly) tick();
      mem_gnt_i = 1'b1;
      tick();
      mem_gnt_i = 1'b0;
      repeat (rdly) tick();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = data;
      tick();
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
    end
  endtask

  // Monitor: pops expected traffic whenever the DUT presents a handshake or response.
  logic          prev_req  = 1'b0;
  logic          prev_gnt  = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  always @(negedge clk) begin
    if (!rst_ni) begin
      prev_req = 1'b0;
      prev_gnt = 1'b0;
    end else begin
      if (prev_req && !prev_gnt) begin
        check("mem_req_held", mem_req_o, 1);
        check("mem_addr_stable", mem_addr_o, prev_addr);
      end
      if (mem_req_o && mem_gnt_i) begin
        if (exp_mem.size() == 0) check("mem_req_unexpected", mem_req_o, 0);
        else check("mem_addr", mem_addr_o, exp_mem.pop_front());
      end
      if (dm_rvalid_o) begin
        if (exp_dm.size() == 0) check("dm_rvalid_unexpected", dm_rvalid_o, 0);
        else check("dm_rdata", dm_rdata_o, exp_dm.pop_front());
      end
      if (pf_rvalid_o) begin
        if (exp_pf.size() == 0) check("pf_rvalid_unexpected", pf_rvalid_o, 0);
        else check("pf_rdata", pf_rdata_o, exp_pf.pop_front());
      end
      prev_req  = mem_req_o;
      prev_gnt  = mem_gnt_i;
      prev_addr = mem_addr_o;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", mem_req_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_dm_gnt", dm_gnt_o, 0);
    check("rst_pf_busy", pf_busy_o, 0);
    rst_ni = 1'b1;
    tick();

    // Demand only
    dm_addr_i = 32'h8000_0040;
    dm_req_i  = 1'b1;
    exp_mem.push_back(32'h8000_0040);
    exp_dm.push_back(D_A5);
    @(negedge clk);
    check("t1_dm_gnt", dm_gnt_o, 1);
    check("t1_mem_req_early", mem_req_o, 0);
    tick();
    dm_req_i = 1'b0;
    check("t1_mem_req", mem_req_o, 1);
    check("t1_mem_addr", mem_addr_o, 32'h8000_0040);
    serve(3, 1, D_A5);

    // Demand priority over a same-cycle prefetch
    pf_req_i = 1'b1; pf_addr_i = 32'h100;
    dm_req_i = 1'b1; dm_addr_i = 32'h200;
    exp_mem.push_back(32'h200); exp_mem.push_back(32'h100);
    exp_dm.push_back(D_1); exp_pf.push_back(D_2);
    @(negedge clk);
    check("t2_dm_gnt", dm_gnt_o, 1);
    tick();
    pf_req_i = 1'b0; dm_req_i = 1'b0;
    check("t2_pf_busy", pf_busy_o, 1);
    serve(0, 0, D_1);
    serve(1, 2, D_2);
    check("t2_pf_busy_end", pf_busy_o, 0);

    // Slot overwrite while waiting on demand
    dm_req_i = 1'b1; dm_addr_i = 32'h400;
    exp_mem.push_back(32'h400); exp_dm.push_back(D_3);
    exp_mem.push_back(32'h340); exp_pf.push_back(D_4);
    tick();
    dm_req_i  = 1'b0;
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    pf_req_i = 1'b1; pf_addr_i = 32'h300;
    tick();
    pf_addr_i = 32'h340;
    tick();
    pf_req_i = 1'b0;
    check("t3_pf_busy", pf_busy_o, 1);
    check("t3_one_outstanding", mem_req_o, 0);
    mem_rvalid_i = 1'b1; mem_rdata_i = D_3;
    tick();
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    serve(0, 0, D_4);
`ifdef ICACHE_MEM_ARB_PERF_EN
    check("t3_perf_drop", perf_pf_drop_cnt_o, 1);
`endif

    // Flush while a prefetch is in flight
    pf_req_i = 1'b1; pf_addr_i = 32'h500;
    exp_mem.push_back(32'h500);
    tick();
    pf_req_i = 1'b0;
    check("t4_req_t1", mem_req_o, 0);
    tick();
    check("t4_req_t2", mem_req_o, 1);
    check("t4_addr", mem_addr_o, 32'h500);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("t4_busy_flushed", pf_busy_o, 1);
    mem_rvalid_i = 1'b1; mem_rdata_i = D_X;
    @(negedge clk);
    check("t4_swallowed", pf_rvalid_o, 0);
    tick();
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    check("t4_busy_end", pf_busy_o, 0);
    pf_req_i = 1'b1; pf_addr_i = 32'h540;
    exp_mem.push_back(32'h540); exp_pf.push_back(D_5);
    tick();
    pf_req_i = 1'b0;
    serve(0, 1, D_5);

    // Flush while the prefetch request is still waiting for a grant
    pf_req_i = 1'b1; pf_addr_i = 32'h600;
    exp_mem.push_back(32'h600);
    tick();
    pf_req_i = 1'b0;
    tick();
    flush_i = 1'b1; pf_req_i = 1'b1; pf_addr_i = 32'h640;
    tick();
    flush_i = 1'b0; pf_req_i = 1'b0;
    check("t5_req_held", mem_req_o, 1);
    check("t5_addr_held", mem_addr_o, 32'h600);
    tick();
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = D_X;
    tick();
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t5_no_reissue", mem_req_o, 0);
    end
    check("t5_busy_end", pf_busy_o, 0);
`ifdef ICACHE_MEM_ARB_PERF_EN
    check("perf_dm", perf_dm_cnt_o, 3);
    check("perf_pf", perf_pf_cnt_o, 5);
    check("perf_drop", perf_pf_drop_cnt_o, 3);
`endif

    // Reset in WAIT_DM with a prefetch pending
    dm_req_i = 1'b1; dm_addr_i = 32'h700;
    exp_mem.push_back(32'h700);
    tick();
    dm_req_i  = 1'b0;
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    pf_req_i = 1'b1; pf_addr_i = 32'h740;
    tick();
    pf_req_i = 1'b0;
    check("t6_busy_pre", pf_busy_o, 1);
    mem_rvalid_i = 1'b1; mem_rdata_i = D_X;
    rst_ni = 1'b0;
    #1;
    check("t6_mem_req", mem_req_o, 0);
    check("t6_mem_addr", mem_addr_o, 0);
    check("t6_dm_gnt", dm_gnt_o, 0);
    check("t6_dm_rvalid", dm_rvalid_o, 0);
    check("t6_pf_rvalid", pf_rvalid_o, 0);
    check("t6_pf_busy", pf_busy_o, 0);
`ifdef ICACHE_MEM_ARB_PERF_EN
    check("t6_perf_dm", perf_dm_cnt_o, 0);
    check("t6_perf_pf", perf_pf_cnt_o, 0);
    check("t6_perf_drop", perf_pf_drop_cnt_o, 0);
`endif
    tick();
    mem_rvalid_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
    mem_rvalid_i = 1'b1;
    @(negedge clk);
    check("t6_late_dm_rvalid", dm_rvalid_o, 0);
    check("t6_late_pf_rvalid", pf_rvalid_o, 0);
    tick();
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    repeat (3) tick();
    check("t6_idle_req", mem_req_o, 0);
    check("t6_idle_busy", pf_busy_o, 0);

    check("end_exp_mem_empty", exp_mem.size(), 0);
    check("end_exp_dm_empty", exp_dm.size(), 0);
    check("end_exp_pf_empty", exp_pf.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_mem_arbiter.md
# icache_mem_arbiter

Shares the single I-side DRAM read port between demand refills from the instruction cache and prefetch requests from the stream buffer. Demand misses always win arbitration. Prefetch requests are pulses, so the block captures them in a one-entry pending slot. It keeps at most one memory transaction outstanding and steers each response back to the requester that issued it. On `flush_i` it discards prefetch work that is pending or in flight, while demand traffic continues unaffected.

## Interface
- `ADDR_WIDTH`, default 32: request address width.
- `CL_SIZE`, default `ICACHE_LINE_WIDTH`: cache line width in bits.
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: asynchronous, active-low reset.
- `flush_i`, in, 1: kill pending and in-flight prefetch.
- `dm_req_i`, in, 1: demand request, level; held until `dm_gnt_o`.
- `dm_addr_i`, in, `ADDR_WIDTH`: demand line address; stable while `dm_req_i` is high.
- `dm_gnt_o`, out, 1: demand accepted (1-cycle pulse).
- `dm_rvalid_o`, out, 1: demand refill data valid (1 cycle).
- `dm_rdata_o`, out, `CL_SIZE`: demand refill data.
- `pf_req_i`, in, 1: prefetch request, single-cycle pulse.
- `pf_addr_i`, in, `ADDR_WIDTH`: prefetch address, valid with `pf_req_i`.
- `pf_rvalid_o`, out, 1: prefetch data valid (1 cycle); drives the stream buffer's `mem_req_done_i`.
- `pf_rdata_o`, out, `CL_SIZE`: prefetch data.
- `pf_busy_o`, out, 1: a prefetch is pending or outstanding.
- `mem_req_o`, out, 1: memory request; held until `mem_gnt_i`.
- `mem_addr_o`, out, `ADDR_WIDTH`: memory address; stable while `mem_req_o` is high.
- `mem_gnt_i`, in, 1: memory accepted the request.
- `mem_rvalid_i`, in, 1: memory response valid.
- `mem_rdata_i`, in, `CL_SIZE`: memory response data.

## Operation
- **FSM states:** IDLE, REQ_DM, REQ_PF, WAIT_DM, WAIT_PF.
- **Pending slot:** `pf_pend_q` and `pf_addr_q`.
  - `pf_req_i` sets the slot and loads the address.
  - A new pulse while the slot is full overwrites the address (newest wins).
  - A pulse in the same cycle the slot is issued refills the slot.
- **IDLE:**
  - If `dm_req_i`: `dm_gnt_o`=1 this cycle, latch `dm_addr_i` into `addr_q`, go to REQ_DM.
  - Else if `pf_pend_q` and no `flush_i`: move `pf_addr_q` into `addr_q`, clear the slot, go to REQ_PF.
- **REQ_DM / REQ_PF:** `mem_req_o`=1, `mem_addr_o`=`addr_q`. On `mem_gnt_i`, go to WAIT_DM / WAIT_PF.
- **WAIT_DM:** on `mem_rvalid_i`, `dm_rvalid_o`=1, `dm_rdata_o`=`mem_rdata_i`, go to IDLE.
- **WAIT_PF:** on `mem_rvalid_i`, `pf_rvalid_o`=1 unless `drop_q`; clear `drop_q`; go to IDLE.
- **Flush:**
  - Clears `pf_pend_q`.
  - In REQ_PF or WAIT_PF, sets `drop_q`. The memory request is never retracted: REQ_PF continues until `mem_gnt_i`, and the response is swallowed.
  - A pulse on `pf_req_i` in the flush cycle is discarded.
  - Demand states are unaffected.
- **`pf_busy_o`:** `pf_pend_q` OR state is REQ_PF or WAIT_PF.
- **Unexpected response:** `mem_rvalid_i` in IDLE, REQ_DM or REQ_PF is ignored and produces no output pulse.

## Timing
- **Reset (asynchronous):**
  - State IDLE; `pf_pend_q`, `drop_q`, `addr_q` all 0.
  - Outputs: `mem_req_o`, `mem_addr_o`, `dm_gnt_o`, `dm_rvalid_o`, `pf_rvalid_o`, `pf_busy_o` = 0.
  - Reset mid-transaction abandons the transaction without any response pulse.
- **Grant:** `dm_gnt_o` is combinational in the IDLE cycle where `dm_req_i` is seen. `mem_req_o` rises the next cycle.
- **Prefetch issue:** `pf_req_i` at cycle t while IDLE and no demand gives `mem_req_o` at t+2 (t+1: slot captured; t+1 IDLE picks it; t+2 REQ_PF).
- **Response path:** `dm_rvalid_o`/`pf_rvalid_o` and the data are combinational from `mem_rvalid_i` (0 cycles).
- **Back-to-back:** the FSM returns to IDLE the cycle after the response; the next `mem_req_o` comes no earlier than 2 cycles after `mem_rvalid_i`.
- **Memory accept:** `mem_gnt_i` may arrive in the first REQ cycle.
- **Outstanding limit:** one transaction at a time.

## Configuration
- **`ICACHE_MEM_ARB_PERF_EN` defined:**
  - Adds 32-bit wrapping counters: `perf_dm_cnt_o` (demand grants), `perf_pf_cnt_o` (prefetches issued), `perf_pf_drop_cnt_o` (prefetches overwritten in the slot, killed while pending, or swallowed after flush).
  - Counters reset to 0 and are not cleared by `flush_i`.
- **Not defined:** those ports and counters do not exist; all other behaviour is identical.

## Test plan
- **Demand only:** `dm_req_i`, addr 0x8000_0040 → `dm_gnt_o` same cycle; `mem_req_o` with 0x8000_0040 next cycle; `mem_gnt_i` 3 cycles later; `mem_rvalid_i` with 0xA5..A5 → `dm_rvalid_o`=1 carrying 0xA5..A5, `pf_rvalid_o`=0.
- **Demand priority:** `pf_req_i` 0x100 and `dm_req_i` 0x200 in the same IDLE cycle → memory sees 0x200 first, then 0x100 after that response; each response pulses only its own rvalid.
- **Slot overwrite:** while WAIT_DM, pulse `pf_req_i` with 0x300 then 0x340 → only 0x340 issued; with `ICACHE_MEM_ARB_PERF_EN`, `perf_pf_drop_cnt_o`=1.
- **Flush in flight:** flush in WAIT_PF → `mem_rvalid_i` yields no `pf_rvalid_o`; `pf_busy_o` drops after the response; the next prefetch returns normally.
- **Flush in REQ_PF:** `mem_req_o` held with the same address until `mem_gnt_i`; response swallowed; a `pf_req_i` pulse in the flush cycle is not issued.
- **Reset in WAIT_DM:** assert `rst_ni`=0 → all outputs 0 immediately; a later `mem_rvalid_i` in IDLE produces no rvalid pulse.
